mmio_uart: RTL and testbench



---
 rtl/mmio_uart.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_mmio_uart.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart.sv
// mmio_uart: memory-mapped 8N1 UART with TX/RX FIFOs,
// runtime baud divisor, sticky error flags and level irq.
module mmio_uart #(
  parameter int DIV_RESET = 434,
  parameter int DIVW      = 16,
  parameter int TXLOG     = 3,
  parameter int RXLOG     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic        re,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);

  localparam int TXD = 1 << TXLOG;
  localparam int RXD = 1 << RXLOG;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_DIV  = 2'd2;
  localparam logic [1:0] A_CTRL = 2'd3;

  typedef enum logic [1:0] {
    T_IDLE, T_START, T_DATA, T_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_STOP, R_WAIT
  } rx_state_t;

  logic [DIVW-1:0] div_q;
  logic [DIVW-1:0] div_m1;
  logic [DIVW-1:0] half_m1;
  logic [1:0]      ctrl;
  logic            rxovr;
  logic            ferr;
  logic            txovr;

  logic wr_data;
  logic wr_stat;
  logic wr_div;
  logic wr_ctrl;
  logic unused_bits;

  assign wr_data = cs & we & (addr == A_DATA);
  assign wr_stat = cs & we & (addr == A_STAT);
  assign wr_div  = cs & we & (addr == A_DIV);
  assign wr_ctrl = cs & we & (addr == A_CTRL);
  assign unused_bits = ^wdata;

  assign div_m1  = div_q - 1'b1;
  assign half_m1 = (div_q >> 1) - 1'b1;

  // TX FIFO
  logic [7:0]       tx_mem [TXD];
  logic [TXLOG-1:0] tx_wp;
  logic [TXLOG-1:0] tx_rp;
  logic [TXLOG:0]   tx_cnt;
  logic             tx_full;
  logic             tx_push;
  logic             tx_pop;
  logic             txovr_set;
  logic             txbusy;

  // RX FIFO
  logic [7:0]       rx_mem [RXD];
  logic [RXLOG-1:0] rx_wp;
  logic [RXLOG-1:0] rx_rp;
  logic [RXLOG:0]   rx_cnt;
  logic             rx_full;
  logic             rx_push;
  logic             rx_wr;
  logic             rx_pop;
  logic             rxvalid;
  logic             rxovr_set;
  logic             ferr_set;

  // TX shifter
  tx_state_t       ts;
  logic [DIVW-1:0] tcnt;
  logic [2:0]      tbitn;
  logic [7:0]      tsh;
  logic            tend;

  // RX shifter
  rx_state_t       rs;
  logic [1:0]      rsync;
  logic            rprev;
  logic            rbit;
  logic            fall;
  logic [DIVW-1:0] rcnt;
  logic [2:0]      rbitn;
  logic [7:0]      rsh;
  logic            rend;

  assign tx_full = tx_cnt[TXLOG];
  assign txbusy  = (tx_cnt != '0) | (ts != T_IDLE);
  assign tend    = (tcnt == '0);
  assign tx_pop  = (tx_cnt != '0) &
                   ((ts == T_IDLE) | ((ts == T_STOP) & tend));
  // A pop in the same cycle frees a slot for the push.
  assign tx_push   = wr_data & (~tx_full | tx_pop);
  assign txovr_set = wr_data & ~tx_push;

  assign rx_full  = rx_cnt[RXLOG];
  assign rxvalid  = (rx_cnt != '0);
  assign rx_pop   = cs & re & (addr == A_DATA) & rxvalid;
  assign rbit     = rsync[1];
  assign fall     = rprev & ~rbit;
  assign rend     = (rcnt == '0);
  assign rx_push  = (rs == R_STOP) & rend & rbit;
  assign ferr_set = (rs == R_STOP) & rend & ~rbit;
  assign rx_wr     = rx_push & (~rx_full | rx_pop);
  assign rxovr_set = rx_push & rx_full & ~rx_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= DIVW'(DIV_RESET);
      ctrl  <= '0;
      rxovr <= 1'b0;
      ferr  <= 1'b0;
      txovr <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (wr_div) begin
        div_q <= (wdata[DIVW-1:0] < DIVW'(2)) ?
                 DIVW'(2) : wdata[DIVW-1:0];
      end
      if (wr_ctrl) ctrl <= wdata[1:0];
      rxovr <= rxovr_set | (rxovr & ~(wr_stat & wdata[3]));
      ferr  <= ferr_set  | (ferr  & ~(wr_stat & wdata[4]));
      txovr <= txovr_set | (txovr & ~(wr_stat & wdata[5]));
      irq   <= (ctrl[0] & rxvalid) | (ctrl[1] & ~txbusy);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wdata[7:0];
    if (rx_wr)   rx_mem[rx_wp] <= rsh;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      unique case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: ;
      endcase
      if (rx_wr)  rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      unique case ({rx_wr, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts    <= T_IDLE;
      tx    <= 1'b1;
      tcnt  <= '0;
      tbitn <= '0;
      tsh   <= '0;
    end else if (tx_pop) begin
      ts   <= T_START;
      tx   <= 1'b0;
      tsh  <= tx_mem[tx_rp];
      tcnt <= div_m1;
    end else begin
      unique case (ts)
        T_IDLE: ;
        T_START: begin
          if (tend) begin
            ts    <= T_DATA;
            tx    <= tsh[0];
            tsh   <= tsh >> 1;
            tbitn <= '0;
            tcnt  <= div_m1;
          end else begin
            tcnt <= tcnt - 1'b1;
          end
        end
        T_DATA: begin
          if (tend) begin
            tcnt  <= div_m1;
            tbitn <= tbitn + 1'b1;
            if (tbitn == 3'd7) begin
              ts <= T_STOP;
              tx <= 1'b1;
            end else begin
              tx  <= tsh[0];
              tsh <= tsh >> 1;
            end
          end else begin
            tcnt <= tcnt - 1'b1;
          end
        end
        T_STOP: begin
          if (tend) ts <= T_IDLE;
          else      tcnt <= tcnt - 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsync <= 2'b11;
      rprev <= 1'b1;
      rs    <= R_IDLE;
      rcnt  <= '0;
      rbitn <= '0;
      rsh   <= '0;
    end else begin
      rsync <= {rsync[0], rx};
      rprev <= rbit;
      unique case (rs)
        R_IDLE: begin
          if (fall) begin
            rs   <= R_START;
            rcnt <= half_m1;
          end
        end
        R_START: begin
          if (rend) begin
            // A start bit that is high again is a glitch.
            rs    <= rbit ? R_IDLE : R_DATA;
            rcnt  <= div_m1;
            rbitn <= '0;
          end else begin
            rcnt <= rcnt - 1'b1;
          end
        end
        R_DATA: begin
          if (rend) begin
            rsh   <= {rbit, rsh[7:1]};
            rcnt  <= div_m1;
            rbitn <= rbitn + 1'b1;
            if (rbitn == 3'd7) rs <= R_STOP;
          end else begin
            rcnt <= rcnt - 1'b1;
          end
        end
        R_STOP: begin
          if (rend) rs <= rbit ? R_IDLE : R_WAIT;
          else      rcnt <= rcnt - 1'b1;
        end
        R_WAIT: begin
          if (rbit) rs <= R_IDLE;
        end
        default: rs <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    unique case (addr)
      A_DATA: rdata = {23'b0, rxvalid,
                       rxvalid ? rx_mem[rx_rp] : 8'h00};
      A_STAT: rdata = {8'h00, 8'(rx_cnt), 8'(tx_cnt), 2'b00,
                       txovr, ferr, rxovr, rxvalid, txbusy, tx_full};
      A_DIV:  rdata = 32'(div_q);
      A_CTRL: rdata = {30'b0, ctrl};
    endcase
  end

endmodule

// File: tb/tb_mmio_uart.sv
// tb_mmio_uart: register vectors, loopback scoreboard and
// hand-driven serial corner cases for mmio_uart.
module tb_mmio_uart;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        we;
  logic        re;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        rx;
  logic        irq;
  logic        loop;
  logic        rx_drv;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];

  typedef struct packed {
    logic        w;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  always #5 clk = ~clk;
  assign rx = loop ? tx : rx_drv;

  mmio_uart dut (
    .clk   (clk),
    .reset (reset),
    .cs    (cs),
    .we    (we),
    .re    (re),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .tx    (tx),
    .rx    (rx),
    .irq   (irq)
  );

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(logic [1:0] a, logic pop,
                    output logic [31:0] v);
    cs = 1'b1; re = pop; addr = a;
    #1 v = rdata;
    @(negedge clk);
    cs = 1'b0; re = 1'b0;
  endtask

  task automatic wait_rx(int n, int bound);
    logic [31:0] st;
    st = '0;
    for (int i = 0; i < bound; i++) begin
      rd(2'd1, 1'b0, st);
      if (st[23:16] == n[7:0]) break;
    end
    chk("rx_count_wait", 32'(st[23:16]), n);
  endtask

  task automatic wait_tx_idle(int bound);
    logic [31:0] st;
    st = 32'h2;
    for (int i = 0; i < bound; i++) begin
      rd(2'd1, 1'b0, st);
      if (!st[1]) break;
    end
    chk("tx_idle_wait", 32'(st[1]), 0);
  endtask

  // Drive one 8N1 frame on rx; optionally pop DATA on the
  // cycle the receiver samples the stop bit.
  task automatic send_frame(logic [7:0] b, logic stopb, int dv,
                            logic pop, output logic [31:0] popped);
    logic [9:0] fr;
    int p;
    int len;
    fr = {stopb, b, 1'b0};
    p = 3 + dv / 2 + 9 * dv;
    len = 10 * dv + dv / 2 + 6;
    popped = '0;
    for (int c = 0; c < len; c++) begin
      rx_drv = (c / dv < 10) ? fr[c / dv] : 1'b1;
      if (pop && c == p - 1) begin
        cs = 1'b1; re = 1'b1; addr = 2'd0;
        #1 popped = rdata;
      end
      @(negedge clk);
      cs = 1'b0; re = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] st;
    logic [9:0]  fr55;
    logic [7:0]  b;
    int          n;
    int          dv;
    int          bad;
    logic        exp_tx;

    cs = 0; we = 0; re = 0; addr = 0; wdata = 0;
    loop = 1'b0; rx_drv = 1'b1; reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    chk("reset_tx", 32'(tx), 1);
    chk("reset_irq", 32'(irq), 0);

    tbl[0] = '{1'b0, 2'd1, 32'h0, 32'h0};
    tbl[1] = '{1'b0, 2'd2, 32'h0, 32'd434};
    tbl[2] = '{1'b0, 2'd3, 32'h0, 32'h0};
    tbl[3] = '{1'b0, 2'd0, 32'h0, 32'h0};
    tbl[4] = '{1'b1, 2'd2, 32'd1, 32'd2};
    tbl[5] = '{1'b1, 2'd2, 32'd0, 32'd2};
    tbl[6] = '{1'b1, 2'd2, 32'hFFFF_1234, 32'h1234};
    tbl[7] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h3};
    tbl[8] = '{1'b1, 2'd3, 32'h0, 32'h0};
    tbl[9] = '{1'b1, 2'd2, 32'd4, 32'd4};
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].w) wr(tbl[i].a, tbl[i].d);
      rd(tbl[i].a, 1'b0, v);
      chk($sformatf("vec%0d", i), v, tbl[i].exp);
    end

    // 0x55 frame, DIV=4: start bit appears after the pop edge.
    fr55 = {1'b1, 8'h55, 1'b0};
    wr(2'd0, 32'h55);
    for (int k = 0; k < 45; k++) begin
      exp_tx = (k >= 1 && (k - 1) / 4 < 10) ?
               fr55[(k - 1) / 4] : 1'b1;
      chk($sformatf("tx55_k%0d", k), 32'(tx), 32'(exp_tx));
      rd(2'd1, 1'b0, st);
      chk($sformatf("busy55_k%0d", k), 32'(st[1]),
          (k <= 40) ? 1 : 0);
    end

    // TX FIFO fill while the shifter sits in START.
    for (int i = 0; i < 9; i++) wr(2'd0, 32'($urandom));
    rd(2'd1, 1'b0, st);
    chk("txfull_9", 32'(st[0]), 1);
    chk("txcnt_9", 32'(st[15:8]), 8);
    chk("txovr_9", 32'(st[5]), 0);
    wr(2'd0, 32'hEE);
    rd(2'd1, 1'b0, st);
    chk("txovr_10", 32'(st[5]), 1);
    chk("txcnt_10", 32'(st[15:8]), 8);
    wr(2'd1, 32'h20);
    rd(2'd1, 1'b0, st);
    chk("txovr_w1c", 32'(st[5]), 0);
    chk("txfull_w1c", 32'(st[0]), 1);

    // Reset in mid-frame.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_tx", 32'(tx), 1);
    rd(2'd1, 1'b0, st);
    chk("midreset_stat", st, 0);
    rd(2'd2, 1'b0, v);
    chk("midreset_div", v, 434);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("midreset_tx_quiet", bad, 0);

    // Loopback 0xA3.
    wr(2'd2, 32'd4);
    loop = 1'b1;
    wr(2'd0, 32'hA3);
    wait_rx(1, 300);
    rd(2'd0, 1'b0, v);
    chk("a3_peek", v, 32'h1A3);
    rd(2'd0, 1'b1, v);
    chk("a3_pop", v, 32'h1A3);
    rd(2'd0, 1'b0, v);
    chk("a3_empty", v, 32'h0);
    wait_tx_idle(200);

    // Random loopback bursts against a byte queue.
    for (int r = 0; r < 4; r++) begin
      dv = $urandom_range(3, 10);
      wr(2'd2, 32'(dv));
      n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        wr(2'd0, 32'(b));
        q.push_back(b);
      end
      wait_rx(n, 12 * dv * n + 100);
      wait_tx_idle(12 * dv + 100);
      for (int j = 0; j < n; j++) begin
        rd(2'd0, 1'b1, v);
        b = (q.size() != 0) ? q.pop_front() : 8'h00;
        chk($sformatf("loop_r%0d_b%0d", r, j), v,
            {23'b0, 1'b1, b});
      end
      rd(2'd1, 1'b0, st);
      chk($sformatf("loop_r%0d_flags", r), 32'(st[5:2]), 0);
    end

    // Start-bit glitch and framing error.
    loop = 1'b0;
    rx_drv = 1'b1;
    wr(2'd2, 32'd4);
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (60) @(negedge clk);
    rd(2'd1, 1'b0, st);
    chk("glitch_rxcnt", 32'(st[23:16]), 0);
    chk("glitch_ferr", 32'(st[4]), 0);
    send_frame(8'h5A, 1'b0, 4, 1'b0, v);
    repeat (10) @(negedge clk);
    rd(2'd1, 1'b0, st);
    chk("ferr_set", 32'(st[4]), 1);
    chk("ferr_rxcnt", 32'(st[23:16]), 0);
    wr(2'd1, 32'h10);
    rd(2'd1, 1'b0, st);
    chk("ferr_w1c", 32'(st[4]), 0);
    send_frame(8'h3C, 1'b1, 4, 1'b0, v);
    rd(2'd0, 1'b1, v);
    chk("after_ferr_rx", v, 32'h13C);

    // RX full, simultaneous push/pop, overrun, irq.
    for (int j = 0; j < 8; j++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 4, 1'b0, v);
      q.push_back(b);
    end
    rd(2'd1, 1'b0, st);
    chk("rxfull_cnt", 32'(st[23:16]), 8);
    chk("rxfull_ovr", 32'(st[3]), 0);
    b = 8'($urandom);
    send_frame(b, 1'b1, 4, 1'b1, v);
    chk("pushpop_popped", v, {23'b0, 1'b1, q.pop_front()});
    q.push_back(b);
    rd(2'd1, 1'b0, st);
    chk("pushpop_cnt", 32'(st[23:16]), 8);
    chk("pushpop_ovr", 32'(st[3]), 0);
    send_frame(8'h77, 1'b1, 4, 1'b0, v);
    rd(2'd1, 1'b0, st);
    chk("ovr_set", 32'(st[3]), 1);
    chk("ovr_cnt", 32'(st[23:16]), 8);
    chk("irq_off", 32'(irq), 0);
    wr(2'd3, 32'd1);
    chk("irq_lag", 32'(irq), 0);
    @(negedge clk);
    chk("irq_rx", 32'(irq), 1);
    for (int j = 0; j < 8; j++) begin
      rd(2'd0, 1'b1, v);
      b = (q.size() != 0) ? q.pop_front() : 8'h00;
      chk($sformatf("drain_%0d", j), v, {23'b0, 1'b1, b});
    end
    rd(2'd1, 1'b0, st);
    chk("drain_cnt", 32'(st[23:16]), 0);
    chk("irq_clear", 32'(irq), 0);
    wr(2'd1, 32'h8);
    rd(2'd1, 1'b0, st);
    chk("ovr_w1c", 32'(st[3]), 0);
    wr(2'd3, 32'd2);
    @(negedge clk);
    chk("irq_txidle", 32'(irq), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
